// File: rtl/lut_const_div.sv
// Radix-16 restoring divider by a constant: one quotient nibble per cycle,
// picked from a 16-entry table of divisor multiples built at elaboration.
module lut_const_div #(
   parameter int A_CONST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] dividend,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] quotient,
   output logic [7:0]  remainder
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] dvd;
   logic [7:0]  rem_q;
   logic [15:0] quo_q;
   logic [1:0]  cnt;
   logic [11:0] lut [16];
   logic [11:0] t;
   logic [3:0]  digit;
   logic [7:0]  rem_next;
   logic        accept;

   // d * A_CONST fits in 12 bits for every legal divisor (15 * 255 = 3825)
   for (genvar g = 0; g < 16; g++) begin : g_lut
      assign lut[g] = 12'(g * A_CONST);
   end

   // Table is monotonic, so the last entry that still fits is the digit.
   // Because the partial remainder stays below A_CONST, T never needs more than 12 bits.
   always_comb begin
      t     = {rem_q, dvd[15:12]};
      digit = '0;
      for (int i = 0; i < 16; i++) begin
         if (lut[i] <= t) begin
            digit = 4'(i);
         end
      end
      rem_next = 8'(t - lut[digit]);
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign quotient  = quo_q;
   assign remainder = rem_q;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (cnt == 2'd3) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Results stay in quo_q/rem_q after DONE until the next acceptance clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd   <= dividend;
                  rem_q <= '0;
                  quo_q <= '0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               dvd   <= {dvd[11:0], 4'h0};
               rem_q <= rem_next;
               quo_q <= {quo_q[11:0], digit};
               cnt   <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_const_div.sv
// Self-checking bench: four dividers (7, 2, 255, 1) share one handshake and are
// compared each cycle against a plain-arithmetic model of timing and results.
module tb_lut_const_div;

   localparam int A_VAL [4] = '{7, 2, 255, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] dividend = '0;
   logic        in_ready [4];
   logic        out_valid [4];
   logic [15:0] quo [4];
   logic [7:0]  rem [4];

   int total = 0;
   int bad = 0;

   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [15:0] m_div = '0;

   always #5 clk = ~clk;

   lut_const_div #(.A_CONST(7)) dut7 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .dividend(dividend), .out_valid(out_valid[0]), .out_ready(out_ready),
      .quotient(quo[0]), .remainder(rem[0]));
   lut_const_div #(.A_CONST(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .dividend(dividend), .out_valid(out_valid[1]), .out_ready(out_ready),
      .quotient(quo[1]), .remainder(rem[1]));
   lut_const_div #(.A_CONST(255)) dut255 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .dividend(dividend), .out_valid(out_valid[2]), .out_ready(out_ready),
      .quotient(quo[2]), .remainder(rem[2]));
   lut_const_div #(.A_CONST(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
      .dividend(dividend), .out_valid(out_valid[3]), .out_ready(out_ready),
      .quotient(quo[3]), .remainder(rem[3]));

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
      end
   endtask

   // Model: an accepted dividend emerges four edges later and waits for out_ready
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_div  <= '0;
      end else if (m_done) begin
         if (out_ready) m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_done <= 1'b1;
      end else if (in_valid) begin
         m_div  <= dividend;
         m_left <= 4;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("in_ready[%0d]", k), 32'(in_ready[k]),
                     32'(!rst && !m_done && m_left == 0));
         checkOutput($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_done));
         checkOutput($sformatf("known[%0d]", k), 32'($isunknown({quo[k], rem[k]})), 32'd0);
         if (rst) begin
            checkOutput($sformatf("rst_quo[%0d]", k), 32'(quo[k]), 32'd0);
            checkOutput($sformatf("rst_rem[%0d]", k), 32'(rem[k]), 32'd0);
         end else if (m_done) begin
            checkOutput($sformatf("quo[%0d]", k), 32'(quo[k]), 32'(m_div) / 32'(A_VAL[k]));
            checkOutput($sformatf("rem[%0d]", k), 32'(rem[k]), 32'(m_div) % 32'(A_VAL[k]));
         end
      end
   end

   // Offer one dividend, then wait (bounded) for the result; leaves the bench #1 after that edge
   task automatic applyStimulus(input logic [15:0] dv, input bit keep);
      int w;
      int lat;
      w = 0;
      while (!in_ready[0] && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready[0]) checkOutput("in_ready_wait", 32'd0, 32'd1);
      in_valid = 1'b1;
      dividend = dv;
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
      lat = 0;
      while (!out_valid[0] && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         if (keep) dividend = 16'($urandom);
      end
      checkOutput("latency", 32'(lat), 32'd4);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", 32'(in_ready[0]), 32'd0);
      checkOutput("reset_valid", 32'(out_valid[0]), 32'd0);
      checkOutput("reset_quo", 32'(quo[0]), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      out_ready = 1'b1;
      applyStimulus(16'd1000, 1'b0);
      checkOutput("q7_1000", 32'(quo[0]), 32'd142);
      checkOutput("r7_1000", 32'(rem[0]), 32'd6);
      @(posedge clk); #1;
      checkOutput("consumed", 32'(out_valid[0]), 32'd0);

      applyStimulus(16'hFFFF, 1'b0);
      checkOutput("q2_ffff", 32'(quo[1]), 32'h7FFF);
      checkOutput("r2_ffff", 32'(rem[1]), 32'd1);
      checkOutput("q255_65535", 32'(quo[2]), 32'd257);
      checkOutput("r255_65535", 32'(rem[2]), 32'd0);
      @(posedge clk); #1;

      applyStimulus(16'd0, 1'b0);
      checkOutput("q2_0", 32'(quo[1]), 32'd0);
      checkOutput("r2_0", 32'(rem[1]), 32'd0);
      @(posedge clk); #1;

      applyStimulus(16'd65534, 1'b0);
      checkOutput("q255_65534", 32'(quo[2]), 32'd256);
      checkOutput("r255_65534", 32'(rem[2]), 32'd254);
      @(posedge clk); #1;

      applyStimulus(16'hABCD, 1'b0);
      checkOutput("q1_abcd", 32'(quo[3]), 32'hABCD);
      checkOutput("r1_abcd", 32'(rem[3]), 32'd0);
      @(posedge clk); #1;

      // Backpressure with in_valid held high and a wandering dividend
      out_ready = 1'b0;
      applyStimulus(16'd1234, 1'b1);
      repeat (10) begin
         @(posedge clk); #1;
         dividend = 16'($urandom);
         checkOutput("bp_ready", 32'(in_ready[0]), 32'd0);
         checkOutput("bp_valid", 32'(out_valid[0]), 32'd1);
         checkOutput("bp_quo", 32'(quo[0]), 32'd176);
         checkOutput("bp_rem", 32'(rem[0]), 32'd2);
      end
      out_ready = 1'b1;
      dividend = 16'd4321;
      @(posedge clk); #1;
      checkOutput("release_idle", 32'(in_ready[0]), 32'd1);
      checkOutput("release_valid", 32'(out_valid[0]), 32'd0);
      @(posedge clk); #1;
      checkOutput("second_accept", 32'(in_ready[0]), 32'd0);
      in_valid = 1'b0;
      begin
         int lat;
         lat = 0;
         while (!out_valid[0] && lat < 12) begin
            @(posedge clk); #1;
            lat++;
         end
         checkOutput("bp_latency", 32'(lat), 32'd4);
      end
      checkOutput("q7_4321", 32'(quo[0]), 32'd617);
      checkOutput("r7_4321", 32'(rem[0]), 32'd2);
      @(posedge clk); #1;

      // Reset after two digits of an operation
      in_valid = 1'b1;
      dividend = 16'd5555;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_valid", 32'(out_valid[0]), 32'd0);
      checkOutput("abort_ready", 32'(in_ready[0]), 32'd0);
      checkOutput("abort_quo", 32'(quo[0]), 32'd0);
      checkOutput("abort_rem", 32'(rem[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("abort_no_result", 32'(out_valid[0]), 32'd0);
      applyStimulus(16'd1000, 1'b0);
      checkOutput("q7_after_rst", 32'(quo[0]), 32'd142);
      checkOutput("r7_after_rst", 32'(rem[0]), 32'd6);
      @(posedge clk); #1;

      // Reset while a result is waiting in DONE
      out_ready = 1'b0;
      applyStimulus(16'd999, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("done_abort_valid", 32'(out_valid[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Random traffic, including corner dividends and occasional reset pulses
      repeat (1500) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       dividend = 16'hFFFF;
            1:       dividend = 16'h0000;
            2:       dividend = 16'hFFFE;
            default: dividend = 16'($urandom);
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lut_const_div.md
LUT_CONST_DIV -- requirements
Module: lut_const_div

Interface
REQ-001 Parameter: A_CONST, default 2, constant divisor; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  dividend offered.
REQ-005 Port: in_ready  output  1  block accepts a dividend.
REQ-006 Port: dividend  input  16  unsigned dividend, sampled on input handshake.
REQ-007 Port: out_valid  output  1  quotient/remainder valid.
REQ-008 Port: out_ready  input  1  consumer accepts result.
REQ-009 Port: quotient  output  16  unsigned floor(dividend / A_CONST).
REQ-010 Port: remainder  output  8  unsigned dividend mod A_CONST.

Function
REQ-011 Divider SHALL be the inverse of the team's LUT constant multiplier: radix-16 restoring division driven by a 16-word multiple LUT holding d*A_CONST, d = 0..15, each entry 12 bits, computed at elaboration.
REQ-012 FSM states SHALL be IDLE, BUSY, DONE only; any other encoding SHALL return to IDLE next cycle.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE and rst is low.
REQ-014 Input handshake (in_valid && in_ready at rising edge) SHALL latch dividend, clear partial remainder R (8 bits) and quotient shift register, clear digit counter, and move IDLE -> BUSY.
REQ-015 In BUSY, one quotient digit per cycle, dividend nibbles MSB first: T = R*16 + nibble (12 bits); d = largest value with LUT[d] <= T; R <= T - LUT[d]; quotient <= {quotient[11:0], d}.
REQ-016 Invariant R < A_CONST SHALL hold after every step, so d never exceeds 15 and T never exceeds 12 bits.
REQ-017 Digit counter (2 bits) SHALL wrap after 4 steps; on the 4th BUSY edge, state -> DONE and out_valid -> 1.
REQ-018 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-019 In DONE, quotient, remainder and out_valid SHALL hold stable until out_valid && out_ready at a rising edge; then state -> IDLE and out_valid -> 0.
REQ-020 in_ready SHALL be 0 in BUSY and DONE; no new dividend is accepted in the cycle a result is consumed (next acceptance earliest one cycle later).
REQ-021 dividend and in_valid changes during BUSY/DONE SHALL have no effect.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 A_CONST = 1 SHALL give quotient = dividend, remainder = 0.
REQ-024 quotient and remainder in IDLE/BUSY are don't-care to consumers but SHALL not be X.

Reset
REQ-025 While rst is high: state = IDLE, out_valid = 0, in_ready = 0, quotient = 0, remainder = 0, digit counter = 0, R = 0.
REQ-026 rst asserted mid-BUSY or in DONE SHALL abort the operation immediately with no result emitted; first acceptance possible on the first rising edge after rst deasserts.

Verification
REQ-027 A_CONST=7, dividend=1000, out_ready=1 -> out_valid 4 edges after accept, quotient=142, remainder=6.
REQ-028 A_CONST=2, dividend=16'hFFFF -> quotient=16'h7FFF, remainder=1; dividend=0 -> quotient=0, remainder=0.
REQ-029 A_CONST=255, dividend=65535 -> quotient=257, remainder=0; dividend=65534 -> quotient=256, remainder=254.
REQ-030 A_CONST=1, dividend=16'hABCD -> quotient=16'hABCD, remainder=0.
REQ-031 Backpressure: out_ready held 0 for 10 cycles in DONE with in_valid=1 and changing dividend -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge, accept one cycle later.
REQ-032 Reset mid-BUSY (after 2 digits) -> out_valid stays 0, all outputs 0; a following dividend=1000 with A_CONST=7 yields 142/6 correctly.
